// File: rtl/signed_pow2_divider_pipelined.sv
// Two-stage valid/ready pipeline for arithmetic/logical right shift and signed divide by 2^S.
// S1 does the shift and remainder detect; S2 applies the round-toward-zero correction.
module signed_pow2_divider_pipelined #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [W-1:0]  up_data,
  input  logic [SW-1:0] up_shift,
  input  logic [1:0]    up_mode,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [W-1:0]  down_data,
  output logic          down_rem_nz
);

  generate
    if (W < 4 || (W & (W - 1)) != 0) begin : g_bad_width
      $error("W must be a power of two and at least 4");
    end
  endgenerate

  localparam logic [1:0] MODE_DIV = 2'b01;
  localparam logic [1:0] MODE_LSR = 2'b10;

  // Result bit i takes operand bit i+s, or the fill bit once i+s runs off the top.
  function automatic logic signed [W-1:0] shift_sel(input logic [W-1:0]  d,
                                                    input logic [SW-1:0] s,
                                                    input logic          fill);
    logic signed [W-1:0] res;
    logic [SW:0]         idx;
    res = '0;
    for (int i = 0; i < W; i++) begin
      idx    = {1'b0, s} + (SW+1)'(i);
      res[i] = (idx < (SW+1)'(W)) ? d[idx[SW-1:0]] : fill;
    end
    return res;
  endfunction

  function automatic logic rem_detect(input logic [W-1:0]  d,
                                      input logic [SW-1:0] s);
    logic r;
    r = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (SW'(i) < s) r = r | d[i];
    end
    return r;
  endfunction

  // Floor result plus one turns floor into truncation for negative inexact quotients.
  function automatic logic signed [W-1:0] div_round(input logic signed [W-1:0] q,
                                                    input logic                bump);
    return q + $signed({{(W-1){1'b0}}, bump});
  endfunction

  logic                vld_p1;
  logic signed [W-1:0] data_p1;
  logic                rem_p1;
  logic                fix_p1;

  logic                vld_p2;
  logic signed [W-1:0] data_p2;
  logic                rem_p2;

  logic adv2;
  logic fill_p0;

  assign adv2     = !vld_p2 || down_ready;
  assign up_ready = !vld_p1 || adv2;
  assign fill_p0  = (up_mode != MODE_LSR) && up_data[W-1];

  assign down_valid  = vld_p2;
  assign down_data   = data_p2;
  assign down_rem_nz = rem_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (up_ready) vld_p1 <= up_valid;
      if (adv2)     vld_p2 <= vld_p1;
    end
  end

  // p0 -> p1: shift and remainder detect
  always_ff @(posedge clk) begin
    if (up_ready && up_valid) begin
      data_p1 <= shift_sel(up_data, up_shift, fill_p0);
      rem_p1  <= rem_detect(up_data, up_shift);
      fix_p1  <= (up_mode == MODE_DIV) && up_data[W-1];
    end
  end

  // p1 -> p2: divide correction and output register
  always_ff @(posedge clk) begin
    if (adv2 && vld_p1) begin
      data_p2 <= div_round(data_p1, fix_p1 && rem_p1);
      rem_p2  <= rem_p1;
    end
  end

endmodule

// File: doc/signed_pow2_divider_pipelined.md
SIGNED_POW2_DIVIDER_PIPELINED -- requirements
Module: signed_pow2_divider_pipelined

Interface
REQ-001 Parameter W, default 8: data width in bits; SHALL be a power of two, at least 4.
REQ-002 Parameter SW, default $clog2(W): shift-amount width (derived; not overridden).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 up_valid  input  1  upstream has a valid operand.
REQ-006 up_ready  output  1  block accepts an operand this cycle.
REQ-007 up_data  input  W  operand, two's complement (raw bits in LSR mode).
REQ-008 up_shift  input  SW  shift amount S, 0..W-1.
REQ-009 up_mode  input  2  00 ASR (floor), 01 DIV (signed divide by 2^S, truncate toward zero), 10 LSR, 11 reserved (treated as 00).
REQ-010 down_valid  output  1  result valid.
REQ-011 down_ready  input  1  downstream accepts result.
REQ-012 down_data  output  W  result.
REQ-013 down_rem_nz  output  1  1 when any of the S discarded low bits of the operand was nonzero.

Function
REQ-014 Transfer on an interface SHALL occur only in a cycle where valid and ready are both 1.
REQ-015 Pipeline SHALL have exactly 2 register stages: S1 (shift, remainder detect), S2 (DIV correction, output register).
REQ-016 With down_ready held 1, a result SHALL appear on down_valid/down_data exactly 2 cycles after acceptance; throughput 1 operand/cycle.
REQ-017 A stage register SHALL load when it is empty or its contents are transferred onward in the same cycle; otherwise it holds.
REQ-018 up_ready SHALL be 1 when S1 is empty or S1 advances into S2 in the same cycle (no combinational path from up_valid to up_ready).
REQ-019 While down_valid=1 and down_ready=0, down_data and down_rem_nz SHALL remain stable.
REQ-020 No operand SHALL be dropped or duplicated under any valid/ready pattern.
REQ-021 ASR: result bit i = operand bit i+S for i+S<=W-1, else operand bit W-1 (sign fill).
REQ-022 LSR: result bit i = operand bit i+S for i+S<=W-1, else 0.
REQ-023 DIV: result = ASR result, plus 1 (mod 2^W) when operand sign bit is 1 and down_rem_nz is 1; the correction add SHALL be in S2.
REQ-024 DIV of most-negative value (-2^(W-1)) by 2^S SHALL equal -2^(W-1-S) exactly; no overflow case exists.
REQ-025 S=0: result equals operand in all modes, down_rem_nz=0.
REQ-026 down_rem_nz SHALL be computed identically in all modes (OR of operand bits S-1..0).
REQ-027 Shift SHALL be built from per-bit selection over S, not by ">>>" or "/"; each stage contains at most one W-bit adder.
REQ-028 Mode 11 SHALL produce results bit-identical to mode 00.

Reset
REQ-029 While rst=1 at a clock edge: both stage valid flags cleared; down_valid=0 next cycle.
REQ-030 Data registers need not be reset; down_data is don't-care while down_valid=0.
REQ-031 up_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight operands; none emerge after reset.

Verification
REQ-033 W=8, data 0xF9 (-7), S=1, mode 00 -> 0xFC (-4), rem_nz=1; mode 01 -> 0xFD (-3); mode 10 -> 0x7C, each 2 cycles after acceptance.
REQ-034 W=8, data 0x80 (-128), S=7: mode 01 -> 0xFF, rem_nz=0; mode 00 -> 0xFF; mode 10 -> 0x01.
REQ-035 W=8, data 0x14 (+20), S=2, mode 01 -> 0x05, rem_nz=0; data 0x15 -> 0x05, rem_nz=1.
REQ-036 Stream 0x00..0x3F with S and mode cycling, down_ready random 50% -> all 64 results in order, each matching reference model; down_data stable while stalled.
REQ-037 Stall: down_ready=0 for 5 cycles with up_valid=1 -> exactly 2 operands accepted, up_ready=0 afterwards, then drains in order when down_ready=1.
REQ-038 Assert rst for 1 cycle with 2 operands in flight -> down_valid=0 next cycle, no stale result ever appears; next operand returns after 2 cycles.
